sal_traffic_gen_chk: RTL



---
 rtl/sal_traffic_gen_chk.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sal_traffic_gen_chk.sv
// Traffic generator/checker: streams 32B write/read transactions and checks returned read data against a seed^address pattern.
// Request and W beats are held stable until accepted; read issue stalls while MAX_OUTS reads are outstanding.
module sal_traffic_gen_chk #(
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int BEATS    = 2,
    parameter int NUM_ID   = 4,
    parameter int MAX_OUTS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      num_txn,
    input  logic [31:0]           seed,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ID_W-1:0]       req_id,
    output logic [ADDR_W-1:0]     req_addr,
    output logic                  req_wr,
    output logic [3:0]            req_len,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [ID_W-1:0]       wid,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [ADDR_W-1:0]     first_err_addr
);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int NW = DATA_W / 32;
    localparam int unsigned LAST_BEAT = BEATS - 1;
    localparam int unsigned DEPTH     = MAX_OUTS;
    localparam int unsigned NID       = NUM_ID;
    localparam logic [PW:0] CNT_ONE   = 1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]        mode_r;
    logic [ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]  num_r;
    logic [31:0]       seed_r;
    logic [CNT_W-1:0]  idx;
    logic              req_acc, w_acc;
    logic [BW-1:0]     wbeat, rbeat;

    logic [ID_W-1:0]   fifo_id   [MAX_OUTS];
    logic [ADDR_W-1:0] fifo_addr [MAX_OUTS];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] s,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [BW-1:0] b);
        logic [DATA_W-1:0] res;
        logic [31:0]       w;
        w = s ^ 32'(a) ^ 32'(b);
        for (int k = 0; k < NW; k++) res[k*32 +: 32] = w;
        return res;
    endfunction

    logic              fifo_full, fifo_empty, start_ok, last_idx;
    logic              req_fire, w_fire, r_fire, wr_txn_done, rd_push, pop, r_err;
    logic [ADDR_W-1:0] cur_addr, head_addr;
    logic [ID_W-1:0]   head_id;

    assign fifo_full  = (count == DEPTH[PW:0]);
    assign fifo_empty = (count == '0);
    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign rready     = busy;
    assign start_ok   = start && !busy;
    assign last_idx   = (idx == num_r - CNT_W'(1));
    assign cur_addr   = base_r + (ADDR_W'(idx) << 5);

    assign req_valid = ((state == S_WR) && !req_acc) || ((state == S_RD) && !fifo_full);
    assign req_wr    = (state == S_WR);
    assign req_id    = ID_W'(32'(idx) % NID);
    assign req_addr  = cur_addr;
    assign req_len   = 4'(LAST_BEAT);
    assign wvalid    = (state == S_WR) && !w_acc;
    assign wid       = req_id;
    assign wdata     = pattern(seed_r, cur_addr, wbeat);
    assign wstrb     = '1;
    assign wlast     = (wbeat == LAST_BEAT[BW-1:0]);

    assign req_fire    = req_valid && req_ready;
    assign w_fire      = wvalid && wready;
    assign r_fire      = rvalid && rready;
    // A write is complete only once both its request and its last beat have been taken, in either order.
    assign wr_txn_done = (state == S_WR) && (req_acc || req_fire) && (w_acc || (w_fire && wlast));
    assign rd_push     = (state == S_RD) && req_fire;

    assign head_id   = fifo_id[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign pop       = r_fire && !fifo_empty && rlast;
    assign r_err     = r_fire && (fifo_empty || (rid != head_id) || (rresp != 2'b00) ||
                                  (rdata != pattern(seed_r, head_addr, rbeat)) ||
                                  (rlast != (rbeat == LAST_BEAT[BW-1:0])));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_txn == '0)      state_nxt = S_DONE;
                    else if (mode == 2'd2)  state_nxt = S_RD;
                    else                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (wr_txn_done) begin
                    if (mode_r == 2'd1)     state_nxt = S_RD;
                    else if (last_idx)      state_nxt = (mode_r == 2'd3) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                if (req_fire) begin
                    if (last_idx)           state_nxt = S_DRAIN;
                    else if (mode_r == 2'd1) state_nxt = S_WR;
                end
            end
            S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r         <= '0;
            base_r         <= '0;
            num_r          <= '0;
            seed_r         <= '0;
            idx            <= '0;
            req_acc        <= 1'b0;
            w_acc          <= 1'b0;
            wbeat          <= '0;
            rbeat          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            if (start_ok) begin
                mode_r         <= mode;
                base_r         <= base_addr & ~ADDR_W'(31);
                num_r          <= num_txn;
                seed_r         <= seed;
                idx            <= '0;
                rbeat          <= '0;
                err_cnt        <= '0;
                first_err_addr <= '0;
            end
            if (wr_txn_done) begin
                req_acc <= 1'b0;
                w_acc   <= 1'b0;
                wbeat   <= '0;
                // Interleave keeps the index so the following read targets the same address.
                if (mode_r != 2'd1) idx <= last_idx ? '0 : idx + CNT_W'(1);
            end else if (state == S_WR) begin
                if (req_fire) req_acc <= 1'b1;
                if (w_fire) begin
                    if (wlast) w_acc <= 1'b1;
                    else       wbeat <= wbeat + BW'(1);
                end
            end
            if (rd_push) begin
                wr_ptr <= wr_ptr + PW'(1);
                idx    <= idx + CNT_W'(1);
            end
            if (r_fire) begin
                rbeat <= (rlast || fifo_empty) ? '0 : rbeat + BW'(1);
                if (r_err) begin
                    if (err_cnt != '1)   err_cnt <= err_cnt + CNT_W'(1);
                    if (err_cnt == '0)   first_err_addr <= fifo_empty ? '0 : head_addr;
                end
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({rd_push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            fifo_id[wr_ptr]   <= req_id;
            fifo_addr[wr_ptr] <= req_addr;
        end
    end
endmodule
